// File: rtl/vga_pkg.sv
// Shared VGA-path definitions: pixel colour type, default visible area,
// transparency code and the layer arbiter state encoding.
package vga_pkg;

  typedef logic [7:0] rgb_t;

  localparam rgb_t TRANSPARENT_ENCODING_DEF = 8'hFF;
  localparam int   X_VISIBLE_DEF            = 640;
  localparam int   Y_VISIBLE_DEF            = 480;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    RUN      = 2'd1,
    LATCHED  = 2'd2
  } arb_state_t;

endpackage : vga_pkg

// File: rtl/priority_encoder_dr.sv
// Lowest-index-wins select over a vector of drawing requests. Shared by the
// layer arbiter and the score/HUD overlay mux.
module priority_encoder_dr #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N) + 1
) (
  input  logic [N-1:0]     i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Scan from the top down so the lowest requesting index is the last write.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = IDX_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule : priority_encoder_dr

// File: rtl/layer_priority_arbiter.sv
// Per-pixel layer arbiter for the VGA path. Picks the highest-priority active
// object layer (or the background), registers the colour, and tracks layer
// overlaps per frame: one pulse on the first overlap, plus a per-layer hit
// snapshot handed over at every start of frame.
module layer_priority_arbiter
  import vga_pkg::*;
#(
  parameter int   NUM_LAYERS           = 4,
  parameter rgb_t TRANSPARENT_ENCODING = TRANSPARENT_ENCODING_DEF,
  parameter int   X_VISIBLE            = X_VISIBLE_DEF,
  parameter int   Y_VISIBLE            = Y_VISIBLE_DEF
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic                               startOfFrame,
  input  logic [10:0]                        pixelX,
  input  logic [10:0]                        pixelY,
  input  logic [NUM_LAYERS-1:0]              layerDR,
  input  logic [NUM_LAYERS-1:0][7:0]         layerRGB,
  input  logic [7:0]                         BG_RGB,
  input  logic                               border,
  output logic [7:0]                         RGBOut,
  output logic [$clog2(NUM_LAYERS):0]        drawnLayer,
  output logic                               collisionPulse,
  output logic [NUM_LAYERS-1:0]              frameHits
);

  localparam int IDX_W = $clog2(NUM_LAYERS) + 1;
  localparam int SEL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  // Wide enough to count every layer plus the border contributor.
  localparam int CNT_W = $clog2(NUM_LAYERS + 2);

  localparam logic [10:0]      X_LIM  = 11'(X_VISIBLE);
  localparam logic [10:0]      Y_LIM  = 11'(Y_VISIBLE);
  localparam logic [IDX_W-1:0] BG_IDX = IDX_W'(NUM_LAYERS);

  // Control state
  arb_state_t r_state;
  arb_state_t w_state_next;

  // Frame hit tracking
  logic [NUM_LAYERS-1:0] r_hit_acc;
  logic [NUM_LAYERS-1:0] w_hit_acc_next;
  logic [NUM_LAYERS-1:0] r_frame_hits;
  logic [NUM_LAYERS-1:0] w_frame_hits_next;

  // Output register
  rgb_t             r_rgb;
  rgb_t             w_rgb_next;
  logic [IDX_W-1:0] r_layer;
  logic [IDX_W-1:0] w_layer_next;
  logic             r_pulse;
  logic             w_pulse_next;

  // Per-pixel decode
  logic [NUM_LAYERS-1:0] w_active;
  logic                  w_visible;
  logic [CNT_W-1:0]      w_count;
  logic                  w_collision;
  logic [IDX_W-1:0]      w_win_idx;
  logic                  w_win_valid;
  rgb_t                  w_win_rgb;

  // A layer draws only when it requests and its colour is not the see-through code.
  always_comb begin
    w_active = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_active[i] = layerDR[i] && (layerRGB[i] != TRANSPARENT_ENCODING);
    end
  end

  assign w_visible = (pixelX < X_LIM) && (pixelY < Y_LIM);

  // Count contributors at this pixel; the border counts as one more.
  always_comb begin
    w_count = CNT_W'(border);
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_count = w_count + CNT_W'(w_active[i]);
    end
  end

  assign w_collision = w_visible && (w_count >= CNT_W'(2));

  priority_encoder_dr #(
    .N     (NUM_LAYERS),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .i_req   (w_active),
    .o_idx   (w_win_idx),
    .o_valid (w_win_valid)
  );

  assign w_win_rgb = layerRGB[w_win_idx[SEL_W-1:0]];

  // Frame FSM: start of frame hands off the hit snapshot and re-arms the pulse;
  // the start-of-frame pixel itself never takes part in collision detection.
  always_comb begin
    w_state_next      = r_state;
    w_hit_acc_next    = r_hit_acc;
    w_frame_hits_next = r_frame_hits;
    w_pulse_next      = 1'b0;
    if (startOfFrame) begin
      w_frame_hits_next = r_hit_acc;
      w_hit_acc_next    = '0;
      w_state_next      = RUN;
    end else begin
      case (r_state)
        WAIT_SOF: begin
          w_state_next = WAIT_SOF;
        end
        RUN: begin
          if (w_collision) begin
            w_hit_acc_next = r_hit_acc | w_active;
            w_pulse_next   = 1'b1;
            w_state_next   = LATCHED;
          end
        end
        LATCHED: begin
          if (w_collision) begin
            w_hit_acc_next = r_hit_acc | w_active;
          end
        end
        default: begin
          w_state_next = WAIT_SOF;
        end
      endcase
    end
  end

  // Colour select: black until the first frame starts and outside the visible
  // area, otherwise the winning layer or the background.
  always_comb begin
    w_rgb_next   = 8'h00;
    w_layer_next = BG_IDX;
    if (w_visible && ((r_state != WAIT_SOF) || startOfFrame)) begin
      if (w_win_valid) begin
        w_rgb_next   = w_win_rgb;
        w_layer_next = w_win_idx;
      end else begin
        w_rgb_next   = BG_RGB;
        w_layer_next = BG_IDX;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= WAIT_SOF;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Hit accumulator and per-frame snapshot.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hit_acc    <= '0;
      r_frame_hits <= '0;
    end else begin
      r_hit_acc    <= w_hit_acc_next;
      r_frame_hits <= w_frame_hits_next;
    end
  end

  // Registered pixel output and collision pulse.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rgb   <= 8'h00;
      r_layer <= BG_IDX;
      r_pulse <= 1'b0;
    end else begin
      r_rgb   <= w_rgb_next;
      r_layer <= w_layer_next;
      r_pulse <= w_pulse_next;
    end
  end

  assign RGBOut         = r_rgb;
  assign drawnLayer     = r_layer;
  assign collisionPulse = r_pulse;
  assign frameHits      = r_frame_hits;

endmodule : layer_priority_arbiter

// File: tb/tb_layer_priority_arbiter.sv
// Bench for layer_priority_arbiter: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a frame-level model.
module tb_layer_priority_arbiter;

  logic              clk = 1'b0;
  logic              resetN;
  logic              startOfFrame;
  logic [10:0]       pixelX, pixelY;
  logic [3:0]        layerDR;
  logic [3:0][7:0]   layerRGB;
  logic [7:0]        BG_RGB;
  logic              border;
  logic [7:0]        RGBOut;
  logic [2:0]        drawnLayer;
  logic              collisionPulse;
  logic [3:0]        frameHits;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: has a frame started since reset, has this frame pulsed yet,
  // hits gathered this frame, and the last snapshot.
  bit         m_started, m_pulsed;
  logic [3:0] m_hit, m_frame;
  logic [7:0] e_rgb;
  logic [2:0] e_layer;
  logic       e_pulse;

  typedef struct {
    logic [3:0]  dr;
    logic [31:0] rgb;
    logic [7:0]  bg;
    logic        bd;
    logic [10:0] x, y;
    logic [7:0]  e_rgb;
    logic [2:0]  e_layer;
    logic        e_pulse;
    logic [3:0]  e_hits;
  } vec_t;

  vec_t tbl[11];

  layer_priority_arbiter dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .layerDR        (layerDR),
    .layerRGB       (layerRGB),
    .BG_RGB         (BG_RGB),
    .border         (border),
    .RGBOut         (RGBOut),
    .drawnLayer     (drawnLayer),
    .collisionPulse (collisionPulse),
    .frameHits      (frameHits)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] dr, input logic [31:0] rgb, input logic [7:0] bg,
                              input logic bd, input int x, input int y, input logic [7:0] er,
                              input int el, input logic ep, input logic [3:0] eh);
    vec_t v;
    v.dr = dr; v.rgb = rgb; v.bg = bg; v.bd = bd;
    v.x = 11'(x); v.y = 11'(y);
    v.e_rgb = er; v.e_layer = 3'(el); v.e_pulse = ep; v.e_hits = eh;
    return v;
  endfunction

  task automatic model_reset();
    m_started = 0; m_pulsed = 0; m_hit = '0; m_frame = '0;
    e_rgb = 8'h00; e_layer = 3'd4; e_pulse = 1'b0;
  endtask

  // Frame-level rules applied to the inputs presented for the coming edge.
  task automatic model_cycle();
    int  n, win;
    bit  vis;
    logic [3:0] act;
    vis = (int'(pixelX) < 640) && (int'(pixelY) < 480);
    n   = int'(border);
    win = -1;
    for (int i = 0; i < 4; i++) begin
      act[i] = layerDR[i] && (layerRGB[i] != 8'hFF);
      if (act[i]) begin
        n++;
        if (win < 0) win = i;
      end
    end
    if (!vis || (!m_started && !startOfFrame)) begin
      e_rgb = 8'h00; e_layer = 3'd4;
    end else if (win >= 0) begin
      e_rgb = layerRGB[win]; e_layer = 3'(win);
    end else begin
      e_rgb = BG_RGB; e_layer = 3'd4;
    end
    e_pulse = 1'b0;
    if (startOfFrame) begin
      m_frame = m_hit; m_hit = '0; m_started = 1; m_pulsed = 0;
    end else if (m_started && vis && n >= 2) begin
      m_hit = m_hit | act;
      if (!m_pulsed) begin
        e_pulse = 1'b1; m_pulsed = 1;
      end
    end
  endtask

  // Present one pixel, clock it, and compare every output with the model.
  task automatic step(input logic sof, input int x, input int y, input logic [3:0] dr,
                      input logic [31:0] rgb, input logic [7:0] bg, input logic bd);
    startOfFrame = sof;
    pixelX = 11'(x); pixelY = 11'(y);
    layerDR = dr; layerRGB = rgb; BG_RGB = bg; border = bd;
    model_cycle();
    @(posedge clk); #1;
    check("rgb",   32'(RGBOut),         32'(e_rgb));
    check("layer", 32'(drawnLayer),     32'(e_layer));
    check("pulse", 32'(collisionPulse), 32'(e_pulse));
    check("hits",  32'(frameHits),      32'(m_frame));
  endtask

  task automatic sof_step();
    step(1'b1, 0, 0, 4'b0000, 32'hFFFFFFFF, 8'h00, 1'b0);
  endtask

  initial begin
    // Vector table: each applied in RUN at the start of a fresh frame,
    // followed by a start of frame that exposes that frame's hits.
    tbl[0]  = mk(4'b0110, 32'hFFE01CFF, 8'h6D, 1'b0, 100, 100, 8'h1C, 1, 1'b1, 4'b0110);
    tbl[1]  = mk(4'b0001, 32'h1F1F1FFF, 8'h6D, 1'b0, 50,  60,  8'h6D, 4, 1'b0, 4'b0000);
    tbl[2]  = mk(4'b0011, 32'hFFFF1C03, 8'h6D, 1'b0, 700, 100, 8'h00, 4, 1'b0, 4'b0000);
    tbl[3]  = mk(4'b0001, 32'hFFFFFF03, 8'h6D, 1'b0, 10,  480, 8'h00, 4, 1'b0, 4'b0000);
    tbl[4]  = mk(4'b1000, 32'hE3FFFFFF, 8'h6D, 1'b1, 639, 479, 8'hE3, 3, 1'b1, 4'b1000);
    tbl[5]  = mk(4'b0000, 32'hFFFFFFFF, 8'h6D, 1'b1, 5,   5,   8'h6D, 4, 1'b0, 4'b0000);
    tbl[6]  = mk(4'b1111, 32'h1FE01C03, 8'h6D, 1'b0, 320, 240, 8'h03, 0, 1'b1, 4'b1111);
    tbl[7]  = mk(4'b0101, 32'hFFE0FFFF, 8'h6D, 1'b0, 1,   1,   8'hE0, 2, 1'b0, 4'b0000);
    tbl[8]  = mk(4'b0000, 32'h01020304, 8'h25, 1'b0, 7,   9,   8'h25, 4, 1'b0, 4'b0000);
    tbl[9]  = mk(4'b1010, 32'h1FFFFFFF, 8'h6D, 1'b1, 300, 200, 8'h1F, 3, 1'b1, 4'b1000);
    tbl[10] = mk(4'b0011, 32'hFFFF1C03, 8'h6D, 1'b1, 640, 0,   8'h00, 4, 1'b0, 4'b0000);

    resetN = 1'b0; startOfFrame = 1'b0; pixelX = '0; pixelY = '0;
    layerDR = '0; layerRGB = '1; BG_RGB = '0; border = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rgb",   32'(RGBOut),         32'h00);
    check("reset_layer", 32'(drawnLayer),     32'd4);
    check("reset_pulse", 32'(collisionPulse), 32'd0);
    check("reset_hits",  32'(frameHits),      32'd0);
    resetN = 1'b1;

    // Before any start of frame: black output, overlaps not recorded.
    step(1'b0, 100, 100, 4'b0011, 32'hFFFF1C03, 8'h6D, 1'b0);
    check("presof_black", 32'(RGBOut), 32'h00);
    check("presof_nopulse", 32'(collisionPulse), 32'd0);
    sof_step();
    step(1'b0, 20, 20, 4'b0000, 32'hFFFFFFFF, 8'h6D, 1'b0);
    sof_step();
    check("presof_hits_zero", 32'(frameHits), 32'd0);

    // Table-driven vectors.
    for (int k = 0; k < 11; k++) begin
      step(1'b0, int'(tbl[k].x), int'(tbl[k].y), tbl[k].dr, tbl[k].rgb, tbl[k].bg, tbl[k].bd);
      check($sformatf("vec%0d_rgb", k),   32'(RGBOut),         32'(tbl[k].e_rgb));
      check($sformatf("vec%0d_layer", k), 32'(drawnLayer),     32'(tbl[k].e_layer));
      check($sformatf("vec%0d_pulse", k), 32'(collisionPulse), 32'(tbl[k].e_pulse));
      sof_step();
      check($sformatf("vec%0d_hits", k),  32'(frameHits),      32'(tbl[k].e_hits));
    end

    // Border overlap held for five cycles: one pulse only.
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 200 + k, 50, 4'b1000, 32'h1CFFFFFF, 8'h6D, 1'b1);
      check($sformatf("border_pulse%0d", k), 32'(collisionPulse), (k == 0) ? 32'd1 : 32'd0);
    end
    sof_step();
    check("border_hits", 32'(frameHits), 32'b1000);

    // Off-screen overlap leaves the accumulator alone.
    step(1'b0, 10, 10, 4'b0101, 32'hFFE0FF03, 8'h6D, 1'b0);
    step(1'b0, 700, 10, 4'b0011, 32'hFFFF1C03, 8'h6D, 1'b0);
    check("offscreen_rgb", 32'(RGBOut), 32'h00);
    check("offscreen_nopulse", 32'(collisionPulse), 32'd0);
    sof_step();
    check("offscreen_hits", 32'(frameHits), 32'b0101);

    // Reset in the middle of a frame with non-zero state.
    step(1'b0, 30, 30, 4'b0011, 32'hFFFF1C03, 8'h6D, 1'b0);
    sof_step();
    step(1'b0, 31, 30, 4'b1100, 32'h1FE0FFFF, 8'h6D, 1'b0);
    check("pre_reset_hits", 32'(frameHits), 32'b0011);
    #2 resetN = 1'b0;
    #1;
    check("midreset_rgb",   32'(RGBOut),         32'h00);
    check("midreset_layer", 32'(drawnLayer),     32'd4);
    check("midreset_pulse", 32'(collisionPulse), 32'd0);
    check("midreset_hits",  32'(frameHits),      32'd0);
    model_reset();
    @(posedge clk); #1;
    resetN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 40 + k, 40, 4'b0011, 32'hFFFF1C03, 8'h6D, 1'b1);
      check($sformatf("postreset_black%0d", k), 32'(RGBOut), 32'h00);
    end
    sof_step();
    check("postreset_hits", 32'(frameHits), 32'd0);

    // Start of frame on an overlapping pixel.
    step(1'b0, 60, 60, 4'b0110, 32'hFFE01CFF, 8'h6D, 1'b0);
    step(1'b1, 61, 60, 4'b0101, 32'hFFE0FF03, 8'h6D, 1'b0);
    check("sofcoll_nopulse", 32'(collisionPulse), 32'd0);
    check("sofcoll_rgb", 32'(RGBOut), 32'h03);
    check("sofcoll_prev_hits", 32'(frameHits), 32'b0110);
    step(1'b0, 62, 60, 4'b0000, 32'hFFFFFFFF, 8'h6D, 1'b0);
    sof_step();
    check("sofcoll_hits_zero", 32'(frameHits), 32'd0);

    // Back-to-back starts of frame.
    step(1'b0, 70, 70, 4'b1001, 32'h1FFFFF03, 8'h6D, 1'b0);
    sof_step();
    check("b2b_first", 32'(frameHits), 32'b1001);
    sof_step();
    check("b2b_second", 32'(frameHits), 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] rgb;
      logic [3:0]  dr;
      logic        sof;
      for (int i = 0; i < 4; i++)
        rgb[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      dr  = 4'($urandom) & 4'($urandom);
      sof = ($urandom_range(0, 39) == 0);
      step(sof, int'($urandom_range(0, 760)), int'($urandom_range(0, 560)), dr, rgb,
           8'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_layer_priority_arbiter
